// File: rtl/eth_rx_pkg.sv
// Shared constants and enums for the byte-wide Ethernet receiver.
package eth_rx_pkg;

  localparam int unsigned HDR_LEN   = 14;
  localparam int unsigned FCS_LEN   = 4;
  localparam int unsigned MAC_BYTES = 6;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [47:0] BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;

  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_TAIL,
    ST_DROP,
    ST_DONE
  } rx_state_t;

  typedef enum logic [2:0] {
    ERR_NONE   = 3'd0,
    ERR_CRC    = 3'd1,
    ERR_RUNT   = 3'd2,
    ERR_TRUNC  = 3'd3,
    ERR_LEN    = 3'd4,
    ERR_RXER   = 3'd5,
    ERR_FILTER = 3'd6
  } rx_err_t;

endpackage

// File: rtl/crc32_d8_rx.sv
// Reflected CRC-32 register, advanced one byte (LSB first) per enabled cycle.
module crc32_d8_rx (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        clr,
  input  logic [7:0]  data,
  output logic [31:0] crc
);
  import eth_rx_pkg::*;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY_REFL) : (r >> 1);
    end
    return r;
  endfunction

  logic [31:0] crc_next;

  assign crc_next = crc_step(crc, data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= CRC_INIT;
    end else if (clr) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc_next;
    end
  end

endmodule

// File: rtl/ethernet_receiver.sv
// Byte-wide Ethernet frame receiver: strips framing/pad, streams payload, checks FCS.
// Optional destination filtering is compiled in with RX_MAC_FILTER_EN.
module ethernet_receiver #(
  parameter logic [47:0] LOCAL_MAC = 48'hCA36_9F2B_47D8,
  parameter int unsigned MAX_LEN   = 1500,
  parameter int unsigned MIN_FRAME = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_dv,
  input  logic [7:0]  rx_data,
  input  logic        rx_er,
  output logic [7:0]  data_out,
  output logic        valid_out,
  output logic        sof,
  output logic        frame_done,
  output logic        crc_ok,
  output logic        frame_err,
  output logic [2:0]  err_code,
  output logic [47:0] src_mac,
  output logic [15:0] rx_len
);
  import eth_rx_pkg::*;

`ifdef RX_MAC_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif

  rx_state_t   state_q, state_d;
  logic [15:0] byte_cnt_q, byte_cnt_d, byte_inc;
  logic [55:0] hdr_sr_q, hdr_sr_d;
  logic        er_seen_q, er_seen_d;
  rx_err_t     drop_code_q, drop_code_d;
  rx_err_t     done_code;

  logic [7:0]  data_out_d;
  logic        valid_d, sof_d, frame_done_d, crc_ok_d, frame_err_d;
  logic [2:0]  err_code_d;
  logic [47:0] src_mac_d;
  logic [15:0] rx_len_d;

  logic        crc_en, crc_clr;
  logic [31:0] crc_q;
  logic [15:0] len_field;
  logic [47:0] dest_mac;
  logic        dest_hit;

  crc32_d8_rx u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (crc_en),
    .clr   (crc_clr),
    .data  (rx_data),
    .crc   (crc_q)
  );

  // Header fields are assembled from the shift register plus the byte being sampled.
  assign len_field = {hdr_sr_q[7:0], rx_data};
  assign dest_mac  = {hdr_sr_q[39:0], rx_data};
  assign dest_hit  = (dest_mac == BROADCAST_MAC) || (dest_mac == LOCAL_MAC);
  assign byte_inc  = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    hdr_sr_d     = hdr_sr_q;
    er_seen_d    = er_seen_q;
    drop_code_d  = drop_code_q;
    done_code    = ERR_NONE;
    data_out_d   = data_out;
    valid_d      = 1'b0;
    sof_d        = 1'b0;
    frame_done_d = 1'b0;
    crc_ok_d     = crc_ok;
    frame_err_d  = frame_err;
    err_code_d   = err_code;
    src_mac_d    = src_mac;
    rx_len_d     = rx_len;
    crc_en       = 1'b0;
    crc_clr      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        drop_code_d = ERR_NONE;
        if (rx_dv && rx_data == PREAMBLE_BYTE) state_d = ST_PREAMBLE;
      end

      ST_PREAMBLE: begin
        if (!rx_dv) begin
          state_d = ST_IDLE;
        end else if (rx_data == SFD_BYTE) begin
          state_d     = ST_HEADER;
          crc_clr     = 1'b1;
          byte_cnt_d  = 16'd0;
          er_seen_d   = 1'b0;
          drop_code_d = ERR_NONE;
        end else if (rx_data != PREAMBLE_BYTE) begin
          state_d = ST_DROP;
        end
      end

      ST_HEADER: begin
        if (!rx_dv) begin
          state_d = ST_DONE;
        end else begin
          crc_en     = 1'b1;
          byte_cnt_d = byte_inc;
          hdr_sr_d   = {hdr_sr_q[47:0], rx_data};
          if (rx_er) er_seen_d = 1'b1;
          if (FILTER_EN && byte_cnt_q == 16'(MAC_BYTES - 1) && !dest_hit) begin
            state_d     = ST_DROP;
            drop_code_d = ERR_FILTER;
          end else if (byte_cnt_q == 16'(HDR_LEN - 1)) begin
            if (len_field == 16'd0 || len_field > 16'(MAX_LEN)) begin
              state_d     = ST_DROP;
              drop_code_d = ERR_LEN;
            end else begin
              state_d   = ST_PAYLOAD;
              rx_len_d  = len_field;
              src_mac_d = hdr_sr_q[55:8];
            end
          end
        end
      end

      ST_PAYLOAD: begin
        if (!rx_dv) begin
          state_d = ST_DONE;
        end else begin
          crc_en     = 1'b1;
          byte_cnt_d = byte_inc;
          if (rx_er) er_seen_d = 1'b1;
          valid_d    = 1'b1;
          data_out_d = rx_data;
          sof_d      = (byte_cnt_q == 16'(HDR_LEN));
          if (byte_cnt_q == 16'(HDR_LEN) + rx_len - 16'd1) state_d = ST_TAIL;
        end
      end

      ST_TAIL: begin
        if (!rx_dv) begin
          state_d = ST_DONE;
        end else begin
          crc_en     = 1'b1;
          byte_cnt_d = byte_inc;
          if (rx_er) er_seen_d = 1'b1;
        end
      end

      ST_DROP: begin
        // Preamble errors carry no code and vanish without a frame_done.
        if (!rx_dv) state_d = (drop_code_q != ERR_NONE) ? ST_DONE : ST_IDLE;
      end

      ST_DONE: begin
        if (drop_code_q != ERR_NONE)                                      done_code = drop_code_q;
        else if (er_seen_q)                                               done_code = ERR_RXER;
        else if (byte_cnt_q < 16'(HDR_LEN) + rx_len + 16'(FCS_LEN))       done_code = ERR_TRUNC;
        else if (byte_cnt_q < 16'(MIN_FRAME))                             done_code = ERR_RUNT;
        else if (crc_q != CRC_RESIDUE)                                    done_code = ERR_CRC;
        else                                                              done_code = ERR_NONE;
        frame_done_d = 1'b1;
        err_code_d   = done_code;
        frame_err_d  = (done_code != ERR_NONE);
        crc_ok_d     = (crc_q == CRC_RESIDUE);
        drop_code_d  = ERR_NONE;
        state_d      = (rx_dv && rx_data == PREAMBLE_BYTE) ? ST_PREAMBLE : ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      byte_cnt_q  <= 16'd0;
      hdr_sr_q    <= 56'd0;
      er_seen_q   <= 1'b0;
      drop_code_q <= ERR_NONE;
      data_out    <= 8'd0;
      valid_out   <= 1'b0;
      sof         <= 1'b0;
      frame_done  <= 1'b0;
      crc_ok      <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= 3'd0;
      src_mac     <= 48'd0;
      rx_len      <= 16'd0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      hdr_sr_q    <= hdr_sr_d;
      er_seen_q   <= er_seen_d;
      drop_code_q <= drop_code_d;
      data_out    <= data_out_d;
      valid_out   <= valid_d;
      sof         <= sof_d;
      frame_done  <= frame_done_d;
      crc_ok      <= crc_ok_d;
      frame_err   <= frame_err_d;
      err_code    <= err_code_d;
      src_mac     <= src_mac_d;
      rx_len      <= rx_len_d;
    end
  end

endmodule

// File: tb/tb_ethernet_receiver.sv
// Directed, table-driven bench for ethernet_receiver with hand-written reset and back-to-back cases.
module tb_ethernet_receiver;

  localparam logic [47:0] SRC_A  = 48'hCA36_9F2B_47D8;
  localparam logic [47:0] SRC_B  = 48'h0200_0000_0001;
  localparam logic [47:0] BCAST  = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] LOCAL  = 48'hCA36_9F2B_47D8;
  localparam logic [47:0] OTHER  = 48'h0102_0304_0506;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_dv;
  logic [7:0]  rx_data;
  logic        rx_er;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        sof;
  logic        frame_done;
  logic        crc_ok;
  logic        frame_err;
  logic [2:0]  err_code;
  logic [47:0] src_mac;
  logic [15:0] rx_len;

  ethernet_receiver dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_dv      (rx_dv),
    .rx_data    (rx_data),
    .rx_er      (rx_er),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .sof        (sof),
    .frame_done (frame_done),
    .crc_ok     (crc_ok),
    .frame_err  (frame_err),
    .err_code   (err_code),
    .src_mac    (src_mac),
    .rx_len     (rx_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [47:0] dest;
    logic [47:0] src;
    logic [15:0] len;
    int          npay;
    logic [7:0]  base;
    logic [7:0]  step;
    int          npad;
    bit          corrupt;
    int          ntx;
    int          er_idx;
    int          exp_nvalid;
    logic [2:0]  exp_err;
    int          exp_crc;
    logic [15:0] exp_rx_len;
    logic [47:0] exp_src;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  // Output monitor: only ever increments, the test works with deltas.
  int         n_valid  = 0;
  int         sof_cnt  = 0;
  int         sof_bad  = 0;
  int         done_cnt = 0;
  logic [7:0] got [0:4095];
  logic [2:0] st_err;
  logic       st_crc, st_ferr;

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_out) begin
        if (n_valid < 4096) got[n_valid] = data_out;
        if (sof) sof_cnt++;
        n_valid++;
      end else if (sof) begin
        sof_bad++;
      end
      if (frame_done) begin
        done_cnt++;
        st_err  = err_code;
        st_crc  = crc_ok;
        st_ferr = frame_err;
      end
    end
  end

  // Index (absolute) of the most recent byte that carried sof.
  int sof_pos = -1;
  always @(negedge clk) begin
    if (rst_n && valid_out && sof) sof_pos = n_valid;
  end

  logic [7:0] fr_buf [0:1599];
  int         fr_len;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  task automatic push(input logic [7:0] b);
    fr_buf[fr_len] = b;
    fr_len++;
  endtask

  task automatic build_frame(input logic [47:0] dest, input logic [47:0] src, input logic [15:0] len,
                             input int npay, input logic [7:0] base, input logic [7:0] step,
                             input int npad, input bit corrupt);
    logic [31:0] c;
    logic [31:0] fcs;
    fr_len = 0;
    for (int i = 5; i >= 0; i--) push(dest[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) push(src[i*8 +: 8]);
    push(len[15:8]);
    push(len[7:0]);
    for (int i = 0; i < npay; i++) push(base + step * 8'(i));
    for (int i = 0; i < npad; i++) push(8'h00);
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < fr_len; i++) c = crc_byte(c, fr_buf[i]);
    fcs = ~c;
    push(fcs[7:0]);
    push(fcs[15:8]);
    push(fcs[23:16]);
    push(fcs[31:24]);
    if (corrupt) fr_buf[fr_len-1] = fr_buf[fr_len-1] ^ 8'h01;
  endtask

  // Preamble, SFD, then the first ntx bytes of fr_buf; leaves rx_dv low for one cycle.
  task automatic drive_frame(input int npre, input int ntx, input int er_idx);
    for (int i = 0; i < npre; i++) begin
      @(negedge clk); rx_dv = 1'b1; rx_data = 8'h55; rx_er = 1'b0;
    end
    @(negedge clk); rx_data = 8'hD5;
    for (int i = 0; i < ntx; i++) begin
      @(negedge clk); rx_data = fr_buf[i]; rx_er = (i == er_idx);
    end
    @(negedge clk); rx_dv = 1'b0; rx_er = 1'b0; rx_data = 8'h00;
  endtask

  task automatic wait_done(input int target);
    for (int c = 0; c < 40 && done_cnt < target; c++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    int b_valid, b_done, b_sof, b_sofbad, nv, mism;
    logic [7:0] e;
    build_frame(v.dest, v.src, v.len, v.npay, v.base, v.step, v.npad, v.corrupt);
    b_valid  = n_valid;
    b_done   = done_cnt;
    b_sof    = sof_cnt;
    b_sofbad = sof_bad;
    drive_frame(7, (v.ntx < 0) ? fr_len : v.ntx, v.er_idx);
    wait_done(b_done + 1);
    nv   = n_valid - b_valid;
    mism = 0;
    for (int i = 0; i < v.exp_nvalid && i < nv; i++) begin
      e = v.base + v.step * 8'(i);
      if (got[b_valid + i] !== e) mism++;
    end
    check({v.name, ".frame_done"}, 64'(done_cnt - b_done), 64'(1));
    check({v.name, ".nvalid"},     64'(nv), 64'(v.exp_nvalid));
    check({v.name, ".payload"},    64'(mism), 64'(0));
    check({v.name, ".sof_cnt"},    64'(sof_cnt - b_sof), 64'((v.exp_nvalid > 0) ? 1 : 0));
    if (v.exp_nvalid > 0) check({v.name, ".sof_pos"}, 64'(sof_pos), 64'(b_valid));
    check({v.name, ".sof_stray"},  64'(sof_bad - b_sofbad), 64'(0));
    check({v.name, ".err_code"},   64'(st_err), 64'(v.exp_err));
    check({v.name, ".frame_err"},  64'(st_ferr), 64'(v.exp_err != 3'd0));
    if (v.exp_crc >= 0) check({v.name, ".crc_ok"}, 64'(st_crc), 64'(v.exp_crc));
    check({v.name, ".rx_len"},     64'(rx_len), 64'(v.exp_rx_len));
    check({v.name, ".src_mac"},    64'(src_mac), 64'(v.exp_src));
  endtask

  function automatic vec_t mk(input string name, input logic [47:0] dest, input logic [47:0] src,
                              input logic [15:0] len, input int npay, input logic [7:0] base,
                              input logic [7:0] step, input int npad, input bit corrupt,
                              input int ntx, input int er_idx, input int nv, input logic [2:0] err,
                              input int crc, input logic [15:0] rxl, input logic [47:0] rsrc);
    vec_t v;
    v.name = name; v.dest = dest; v.src = src; v.len = len; v.npay = npay;
    v.base = base; v.step = step; v.npad = npad; v.corrupt = corrupt; v.ntx = ntx;
    v.er_idx = er_idx; v.exp_nvalid = nv; v.exp_err = err; v.exp_crc = crc;
    v.exp_rx_len = rxl; v.exp_src = rsrc;
    return v;
  endfunction

  vec_t vecs [13];

  initial begin
    int b_valid, b_done;

    vecs[0]  = mk("good",      BCAST, SRC_A, 16'd64,   64,   8'h00, 8'h01, 0,  1'b0, -1, -1,   64,  3'd0,  1, 16'd64,   SRC_A);
    vecs[1]  = mk("short",     LOCAL, SRC_B, 16'd3,    3,    8'hAA, 8'h11, 43, 1'b0, -1, -1,   3,   3'd0,  1, 16'd3,    SRC_B);
    vecs[2]  = mk("bad_fcs",   BCAST, SRC_A, 16'd64,   64,   8'h00, 8'h01, 0,  1'b1, -1, -1,   64,  3'd1,  0, 16'd64,   SRC_A);
    vecs[3]  = mk("trunc",     BCAST, SRC_A, 16'd64,   64,   8'h00, 8'h01, 0,  1'b0, 34, -1,   20,  3'd3, -1, 16'd64,   SRC_A);
    vecs[4]  = mk("len_600",   BCAST, SRC_B, 16'h0600, 10,   8'h10, 8'h01, 0,  1'b0, -1, -1,   0,   3'd4, -1, 16'd64,   SRC_A);
    vecs[5]  = mk("rx_er",     BCAST, SRC_A, 16'd64,   64,   8'h00, 8'h01, 0,  1'b0, -1, 24,   64,  3'd5, -1, 16'd64,   SRC_A);
    vecs[6]  = mk("runt",      BCAST, SRC_B, 16'd3,    3,    8'hAA, 8'h11, 0,  1'b0, -1, -1,   3,   3'd2, -1, 16'd3,    SRC_B);
    vecs[7]  = mk("len_0",     BCAST, SRC_A, 16'd0,    0,    8'h00, 8'h01, 46, 1'b0, -1, -1,   0,   3'd4, -1, 16'd3,    SRC_B);
    vecs[8]  = mk("len_1501",  BCAST, SRC_A, 16'd1501, 5,    8'h00, 8'h01, 0,  1'b0, -1, -1,   0,   3'd4, -1, 16'd3,    SRC_B);
    vecs[9]  = mk("len_1500",  BCAST, SRC_A, 16'd1500, 1500, 8'h00, 8'h01, 0,  1'b0, -1, -1,   1500,3'd0,  1, 16'd1500, SRC_A);
    vecs[10] = mk("hdr_trunc", BCAST, SRC_B, 16'd64,   64,   8'h00, 8'h01, 0,  1'b0, 8,  -1,   0,   3'd3, -1, 16'd1500, SRC_A);
    vecs[11] = mk("end_last",  BCAST, SRC_A, 16'd64,   64,   8'h00, 8'h01, 0,  1'b0, 78, -1,   64,  3'd3, -1, 16'd64,   SRC_A);
`ifdef RX_MAC_FILTER_EN
    vecs[12] = mk("dest_other",OTHER, SRC_B, 16'd5,    5,    8'h40, 8'h02, 41, 1'b0, -1, -1,   0,   3'd6, -1, 16'd64,   SRC_A);
`else
    vecs[12] = mk("dest_other",OTHER, SRC_B, 16'd5,    5,    8'h40, 8'h02, 41, 1'b0, -1, -1,   5,   3'd0,  1, 16'd5,    SRC_B);
`endif

    rst_n = 1'b0; rx_dv = 1'b0; rx_data = 8'h00; rx_er = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.src_mac", 64'(src_mac), 64'(0));
    check("reset.misc", 64'({data_out, valid_out, sof, frame_done, crc_ok, frame_err, err_code, rx_len}), 64'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset in the middle of the payload; the tail of that frame must not produce anything.
    build_frame(BCAST, SRC_A, 16'd64, 64, 8'h00, 8'h01, 0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); rx_dv = 1'b1; rx_data = 8'h55;
    end
    @(negedge clk); rx_data = 8'hD5;
    for (int i = 0; i < 34; i++) begin
      @(negedge clk); rx_data = fr_buf[i];
    end
    @(negedge clk); rx_data = fr_buf[34]; rst_n = 1'b0;
    @(negedge clk); rx_data = fr_buf[35];
    check("midrst.src_mac", 64'(src_mac), 64'(0));
    check("midrst.misc", 64'({data_out, valid_out, sof, frame_done, crc_ok, frame_err, err_code, rx_len}), 64'(0));
    @(negedge clk); rx_data = fr_buf[36]; rst_n = 1'b1;
    b_valid = n_valid;
    b_done  = done_cnt;
    for (int i = 37; i < fr_len; i++) begin
      @(negedge clk); rx_data = fr_buf[i];
    end
    @(negedge clk); rx_dv = 1'b0; rx_data = 8'h00;
    repeat (6) @(negedge clk);
    check("midrst.no_done",  64'(done_cnt - b_done), 64'(0));
    check("midrst.no_valid", 64'(n_valid - b_valid), 64'(0));
    run_vec(vecs[0]);

    // Back-to-back: second frame's single preamble byte lands in the DONE cycle.
    build_frame(LOCAL, SRC_B, 16'd3, 3, 8'hAA, 8'h11, 43, 1'b0);
    b_valid = n_valid;
    b_done  = done_cnt;
    drive_frame(7, fr_len, -1);
    drive_frame(1, fr_len, -1);
    wait_done(b_done + 2);
    check("b2b.frame_done", 64'(done_cnt - b_done), 64'(2));
    check("b2b.nvalid",     64'(n_valid - b_valid), 64'(6));
    check("b2b.second_byte", 64'(got[b_valid + 4]), 64'(8'hBB));
    check("b2b.err_code",   64'(st_err), 64'(0));
    check("b2b.crc_ok",     64'(st_crc), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
